// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers used by the pooling stage and other layers.
package cnn_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int SMAX_W     = 32;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  // Operands are sign-extended to SMAX_W by the caller, so any DATA_W up to 32 bits fits.
  function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a,
                                                    input logic signed [SMAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one horizontal-max result per pooled column of the even row.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int WIDTH = 36,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/maxpool_relu_stream.sv
// Streaming 2x2/stride-2 signed max-pool with one output register and valid/ready on both sides.
// Define POOL_RELU_EN to clamp negative pooled samples to zero.
module maxpool_relu_stream
  import cnn_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IN_W     = 24,
  parameter int IN_H     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic                       out_last
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int BUS_W = CHANNELS * DATA_W;
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IN_H - 1);
  localparam logic [CW-1:0] POOL_COL_END = CW'(2 * OUT_W - 1);
  localparam logic [RW-1:0] POOL_ROW_END = RW'(2 * OUT_H - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [BUS_W-1:0] h_q, h_d;
  logic             out_valid_q, out_valid_d;
  logic [BUS_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             accept;
  logic             in_pool_col;
  logic             in_pool_row;
  logic             lb_wr_en;
  logic             window_done;
  logic [AW-1:0]    lb_addr;
  logic [BUS_W-1:0] lb_rd;
  logic [BUS_W-1:0] hmax;
  logic [BUS_W-1:0] wmax;

  function automatic logic [DATA_W-1:0] max_s(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic signed [SMAX_W-1:0] m;
    m = smax(SMAX_W'($signed(a)), SMAX_W'($signed(b)));
    return m[DATA_W-1:0];
  endfunction

  assign in_ready    = !rst && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign in_pool_col = (col_q <= POOL_COL_END);
  assign in_pool_row = (row_q <= POOL_ROW_END);
  assign lb_addr     = AW'(col_q >> 1);
  // Trailing odd row/column fall outside the pool range and never touch h_reg or the line buffer.
  assign lb_wr_en    = accept && col_q[0] && !row_q[0] && in_pool_row;
  assign window_done = accept && col_q[0] && row_q[0];

  pool_line_buf #(
    .DEPTH (OUT_W),
    .WIDTH (BUS_W),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .addr    (lb_addr),
    .wr_data (hmax),
    .rd_data (lb_rd)
  );

  always_comb begin
    hmax = '0;
    wmax = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      hmax[ch*DATA_W +: DATA_W] = max_s(h_q[ch*DATA_W +: DATA_W], in_data[ch*DATA_W +: DATA_W]);
      wmax[ch*DATA_W +: DATA_W] = max_s(lb_rd[ch*DATA_W +: DATA_W], hmax[ch*DATA_W +: DATA_W]);
`ifdef POOL_RELU_EN
      if (wmax[ch*DATA_W + DATA_W - 1]) begin
        wmax[ch*DATA_W +: DATA_W] = '0;
      end
`else
`endif
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    h_d   = h_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0] && in_pool_col) begin
        h_d = in_data;
      end
    end
  end

  // A completing window always wins over a drain, so the register reloads back-to-back.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (window_done) begin
      out_valid_d = 1'b1;
      out_data_d  = wmax;
      out_last_d  = (col_q == POOL_COL_END) && (row_q == POOL_ROW_END);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      h_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h_q         <= h_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
